// File: rtl/per2axi_r_burst_fifo_pkg.sv
// Shared definitions for the per2axi R-channel burst FIFO: AXI response
// encodings and the stored-entry width helper.
package per2axi_r_burst_fifo_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // One stored beat is {id, user, data, resp(2), last(1)}.
    function automatic int entry_width(input int id_w, input int data_w, input int user_w);
        return 3 + data_w + user_w + id_w;
    endfunction

endpackage

// File: rtl/per2axi_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one
// asynchronous read port, every entry cleared on reset.
module per2axi_fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage: cleared on reset, written at waddr when we is high.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/per2axi_r_burst_fifo.sv
// AXI R-channel buffer: DEPTH-entry FIFO with beat and burst accounting
// and an optional packet mode that holds a burst until its last beat is
// stored (or the FIFO is full, so over-long bursts still drain).
//
// Handshakes: a beat transfers on a side only in a cycle where valid and
// ready are both high; valid never depends on ready, slave_ready_o depends
// only on registered occupancy, and once master_valid_o rises it, and the
// head payload, hold until the beat is taken.
module per2axi_r_burst_fifo
    import per2axi_r_burst_fifo_pkg::*;
#(
    parameter int ID_WIDTH    = 4,
    parameter int DATA_WIDTH  = 64,
    parameter int USER_WIDTH  = 6,
    parameter int DEPTH       = 4,
    parameter int PACKET_MODE = 0,
    parameter int AFULL_THR   = DEPTH - 1,
    parameter int CNT_WIDTH   = $clog2(DEPTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  slave_valid_i,
    output logic                  slave_ready_o,
    input  logic [DATA_WIDTH-1:0] slave_data_i,
    input  logic [1:0]            slave_resp_i,
    input  logic [USER_WIDTH-1:0] slave_user_i,
    input  logic [ID_WIDTH-1:0]   slave_id_i,
    input  logic                  slave_last_i,
    output logic                  master_valid_o,
    input  logic                  master_ready_i,
    output logic [DATA_WIDTH-1:0] master_data_o,
    output logic [1:0]            master_resp_o,
    output logic [USER_WIDTH-1:0] master_user_o,
    output logic [ID_WIDTH-1:0]   master_id_o,
    output logic                  master_last_o,
    output logic [CNT_WIDTH-1:0]  count_o,
    output logic [CNT_WIDTH-1:0]  bursts_o,
    output logic                  almost_full_o
);

    localparam int ENTRY_W = entry_width(ID_WIDTH, DATA_WIDTH, USER_WIDTH);
    localparam int AW      = $clog2(DEPTH);
    localparam logic [CNT_WIDTH-1:0] FULL_CNT  = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] AFULL_CNT = CNT_WIDTH'(AFULL_THR);

    logic [AW-1:0]        wrp;
    logic [AW-1:0]        rdp;
    logic [CNT_WIDTH-1:0] count;
    logic [CNT_WIDTH-1:0] bursts;
    logic                 push;
    logic                 pop;
    logic                 head_ok;
    logic [ENTRY_W-1:0]   wr_entry;
    logic [ENTRY_W-1:0]   rd_entry;

    assign slave_ready_o = (count != FULL_CNT);

    // Packet mode releases the head only when a whole burst is stored, or
    // when the FIFO is full of a burst longer than DEPTH (deadlock escape).
    generate
        if (PACKET_MODE != 0) begin : g_packet
            assign head_ok = (bursts != '0) || (count == FULL_CNT);
        end else begin : g_stream
            assign head_ok = 1'b1;
        end
    endgenerate

    assign master_valid_o = (count != '0) && head_ok;

    assign push = slave_valid_i && slave_ready_o;
    assign pop  = master_valid_o && master_ready_i;

    assign wr_entry = {slave_id_i, slave_user_i, slave_data_i, slave_resp_i, slave_last_i};
    assign {master_id_o, master_user_o, master_data_o, master_resp_o, master_last_o} = rd_entry;

    per2axi_fifo_mem #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .we    (push),
        .waddr (wrp),
        .wdata (wr_entry),
        .raddr (rdp),
        .rdata (rd_entry)
    );

    // Pointers advance on their own handshake and wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrp <= '0;
            rdp <= '0;
        end else begin
            if (push) wrp <= wrp + AW'(1);
            if (pop)  rdp <= rdp + AW'(1);
        end
    end

    // Beat count: +1 push only, -1 pop only, unchanged when both or neither.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + CNT_WIDTH'(1);
                2'b01:   count <= count - CNT_WIDTH'(1);
                default: count <= count;
            endcase
        end
    end

    // Complete-burst count: tracks last beats entering and leaving.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bursts <= '0;
        end else begin
            case ({push && slave_last_i, pop && master_last_o})
                2'b10:   bursts <= bursts + CNT_WIDTH'(1);
                2'b01:   bursts <= bursts - CNT_WIDTH'(1);
                default: bursts <= bursts;
            endcase
        end
    end

    assign count_o       = count;
    assign bursts_o      = bursts;
    assign almost_full_o = (count >= AFULL_CNT);

endmodule

// File: tb/tb_per2axi_r_burst_fifo.sv
// Bench for per2axi_r_burst_fifo: one stream-mode and one packet-mode
// instance share the same stimulus; each is checked every cycle against a
// queue-based model of its own.
module tb_per2axi_r_burst_fifo;
    import per2axi_r_burst_fifo_pkg::*;

    localparam int DEPTH = 4;
    localparam int AFULL = DEPTH - 1;
    localparam int EW    = 4 + 6 + 64 + 3;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        sv;
    logic [3:0]  sid;
    logic [63:0] sdata;
    logic [1:0]  sresp;
    logic [5:0]  suser;
    logic        slast;
    logic        mr;

    logic        r0, v0, l0, af0;
    logic [63:0] d0;
    logic [1:0]  rs0;
    logic [5:0]  u0;
    logic [3:0]  i0;
    logic [2:0]  c0, b0;
    logic        r1, v1, l1, af1;
    logic [63:0] d1;
    logic [1:0]  rs1;
    logic [5:0]  u1;
    logic [3:0]  i1;
    logic [2:0]  c1, b1;

    logic [EW-1:0] q0[$];
    logic [EW-1:0] q1[$];
    int total = 0;
    int bad   = 0;

    // Clock.
    always #5 clk = ~clk;

    per2axi_r_burst_fifo #(.DEPTH(DEPTH), .PACKET_MODE(0)) u_m0 (
        .clk_i(clk), .rst_ni(rst_ni),
        .slave_valid_i(sv), .slave_ready_o(r0), .slave_data_i(sdata), .slave_resp_i(sresp),
        .slave_user_i(suser), .slave_id_i(sid), .slave_last_i(slast),
        .master_valid_o(v0), .master_ready_i(mr), .master_data_o(d0), .master_resp_o(rs0),
        .master_user_o(u0), .master_id_o(i0), .master_last_o(l0),
        .count_o(c0), .bursts_o(b0), .almost_full_o(af0)
    );

    per2axi_r_burst_fifo #(.DEPTH(DEPTH), .PACKET_MODE(1)) u_m1 (
        .clk_i(clk), .rst_ni(rst_ni),
        .slave_valid_i(sv), .slave_ready_o(r1), .slave_data_i(sdata), .slave_resp_i(sresp),
        .slave_user_i(suser), .slave_id_i(sid), .slave_last_i(slast),
        .master_valid_o(v1), .master_ready_i(mr), .master_data_o(d1), .master_resp_o(rs1),
        .master_user_o(u1), .master_id_o(i1), .master_last_o(l1),
        .count_o(c1), .bursts_o(b1), .almost_full_o(af1)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int qsize(input int m);
        return (m == 0) ? q0.size() : q1.size();
    endfunction

    function automatic int qlasts(input int m);
        int n = 0;
        if (m == 0) begin
            foreach (q0[i]) n += int'(q0[i][0]);
        end else begin
            foreach (q1[i]) n += int'(q1[i][0]);
        end
        return n;
    endfunction

    // Stream mode shows any stored beat; packet mode needs a stored last
    // beat somewhere in the FIFO, or a completely full FIFO.
    function automatic logic exp_valid(input int m);
        if (m == 0) return qsize(0) != 0;
        return (qsize(1) != 0) && (qlasts(1) != 0 || qsize(1) == DEPTH);
    endfunction

    task automatic check_all();
        chk("m0_valid",  128'(v0),  128'(exp_valid(0)));
        chk("m0_ready",  128'(r0),  128'(qsize(0) != DEPTH));
        chk("m0_count",  128'(c0),  128'(qsize(0)));
        chk("m0_bursts", 128'(b0),  128'(qlasts(0)));
        chk("m0_afull",  128'(af0), 128'(qsize(0) >= AFULL));
        if (exp_valid(0)) chk("m0_head", 128'({i0, u0, d0, rs0, l0}), 128'(q0[0]));
        chk("m1_valid",  128'(v1),  128'(exp_valid(1)));
        chk("m1_ready",  128'(r1),  128'(qsize(1) != DEPTH));
        chk("m1_count",  128'(c1),  128'(qsize(1)));
        chk("m1_bursts", 128'(b1),  128'(qlasts(1)));
        chk("m1_afull",  128'(af1), 128'(qsize(1) >= AFULL));
        if (exp_valid(1)) chk("m1_head", 128'({i1, u1, d1, rs1, l1}), 128'(q1[0]));
    endtask

    // Driver: check state at this falling edge, apply one cycle of inputs,
    // advance both models by what each instance will accept, then wait.
    task automatic step(input logic v, input logic [3:0] id, input logic [63:0] d,
                        input logic [1:0] rs, input logic [5:0] us, input logic l,
                        input logic r);
        logic ev0, ev1, er0, er1;
        logic [EW-1:0] e;
        check_all();
        sv = v; sid = id; sdata = d; sresp = rs; suser = us; slast = l; mr = r;
        ev0 = exp_valid(0);
        ev1 = exp_valid(1);
        er0 = (q0.size() != DEPTH);
        er1 = (q1.size() != DEPTH);
        e = {id, us, d, rs, l};
        if (ev0 && r) void'(q0.pop_front());
        if (v && er0) q0.push_back(e);
        if (ev1 && r) void'(q1.pop_front());
        if (v && er1) q1.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic r);
        for (int k = 0; k < n; k++) step(1'b0, 4'h0, 64'h0, RESP_OKAY, 6'h0, 1'b0, r);
    endtask

    initial begin
        logic [63:0] rd;
        rst_ni = 1'b0;
        sv = 1'b0; sid = '0; sdata = '0; sresp = '0; suser = '0; slast = 1'b0; mr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_payload0", 128'({i0, u0, d0, rs0, l0}), 128'(0));
        chk("rst_payload1", 128'({i1, u1, d1, rs1, l1}), 128'(0));
        chk("rst_ready0",   128'(r0), 128'(1));
        chk("rst_valid1",   128'(v1), 128'(0));
        rst_ni = 1'b1;
        @(negedge clk);

        // Fill to full with downstream stalled, then release.
        step(1'b1, 4'd3, 64'h11, RESP_OKAY, 6'h01, 1'b0, 1'b0);
        step(1'b1, 4'd3, 64'h22, RESP_OKAY, 6'h02, 1'b0, 1'b0);
        step(1'b1, 4'd3, 64'h33, RESP_OKAY, 6'h03, 1'b0, 1'b0);
        step(1'b1, 4'd3, 64'h44, RESP_OKAY, 6'h04, 1'b1, 1'b0);
        step(1'b1, 4'd3, 64'h55, RESP_OKAY, 6'h05, 1'b1, 1'b0);
        chk("full_count0", 128'(c0),  128'(4));
        chk("full_afull0", 128'(af0), 128'(1));
        chk("full_ready0", 128'(r0),  128'(0));
        idle(6, 1'b1);

        // Streaming with valid and ready high, lasts every fourth beat.
        for (int k = 0; k < 20; k++) begin
            rd = {$urandom, $urandom};
            step(1'b1, 4'($urandom_range(0, 15)), rd, RESP_OKAY, 6'($urandom_range(0, 63)),
                 ((k % 4) == 3), 1'b1);
        end
        idle(6, 1'b1);

        // Three-beat burst, last on the third beat.
        step(1'b1, 4'd5, 64'hA1, RESP_OKAY, 6'h11, 1'b0, 1'b1);
        step(1'b1, 4'd5, 64'hA2, RESP_OKAY, 6'h12, 1'b0, 1'b1);
        step(1'b1, 4'd5, 64'hA3, RESP_EXOKAY, 6'h13, 1'b1, 1'b1);
        idle(5, 1'b1);

        // Six-beat burst longer than DEPTH: packet mode must escape on full.
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 4'd9, 64'hB0 + 64'(k), RESP_OKAY, 6'(k), (k == 5), 1'b1);
        end
        for (int k = 0; k < 10; k++) step(1'b0, 4'd9, 64'h0, RESP_OKAY, 6'h0, 1'b0, 1'b1);
        chk("long_bursts1", 128'(b1), 128'(0));
        chk("long_count1",  128'(c1), 128'(0));

        // Random backpressure with mixed responses.
        for (int k = 0; k < 80; k++) begin
            rd = {$urandom, $urandom};
            step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), rd,
                 ((k % 4) == 1) ? RESP_SLVERR : 2'($urandom_range(0, 3)),
                 6'($urandom_range(0, 63)), ($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)));
        end
        for (int k = 0; k < 4; k++) step(1'b1, 4'd1, 64'hCC, RESP_OKAY, 6'h0, 1'b1, 1'b1);
        idle(8, 1'b1);

        // Reset in the middle of a burst with three beats stored.
        step(1'b1, 4'd7, 64'hD1, RESP_OKAY, 6'h21, 1'b0, 1'b0);
        step(1'b1, 4'd7, 64'hD2, RESP_SLVERR, 6'h22, 1'b0, 1'b0);
        step(1'b1, 4'd7, 64'hD3, RESP_OKAY, 6'h23, 1'b0, 1'b0);
        chk("pre_rst_count0", 128'(c0), 128'(3));
        sv = 1'b0; mr = 1'b0;
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_count0", 128'(c0), 128'(0));
        chk("mid_rst_valid0", 128'(v0), 128'(0));
        chk("mid_rst_ready0", 128'(r0), 128'(1));
        chk("mid_rst_count1", 128'(c1), 128'(0));
        chk("mid_rst_ready1", 128'(r1), 128'(1));
        q0.delete();
        q1.delete();
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);

        // Post-reset burst.
        step(1'b1, 4'd2, 64'hE1, RESP_OKAY, 6'h31, 1'b0, 1'b1);
        step(1'b1, 4'd2, 64'hE2, RESP_DECERR, 6'h32, 1'b0, 1'b1);
        step(1'b1, 4'd2, 64'hE3, RESP_OKAY, 6'h33, 1'b1, 1'b1);
        idle(6, 1'b1);
        check_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
